board_clk_ctrl: RTL

BOARD_CLK_CTRL -- requirements
Module: board_clk_ctrl

---
 rtl/board_clk_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/board_clk_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/board_clk_pkg.sv
// Shared encodings for the board clock controller: operating modes and FSM states.
package board_clk_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT       = 2'b00,
        ST_RUN        = 2'b01,
        ST_STEP_ARMED = 2'b10,
        ST_STEP_FIRE  = 2'b11
    } state_t;

    // The reserved encoding deliberately falls back to HALT.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        state_t st;
        case (mode)
            MODE_RUN:  st = ST_RUN;
            MODE_STEP: st = ST_STEP_ARMED;
            MODE_HALT: st = ST_HALT;
            default:   st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-time debouncer for a raw push-button.
module btn_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_accept;

    // The counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        w_differs = (r_sync2 != r_level);
        w_accept  = w_differs && (r_cnt == CNT_MAX);
    end

    // Synchroniser, stability counter and accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_accept & r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_level <= r_level;
                r_cnt   <= r_cnt + CNT_ONE;
            end else begin
                r_level <= r_level;
                r_cnt   <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/board_clk_ctrl.sv
// Board clock controller: programmable clock-enable divider for a CPU with
// halt / free-run / single-step modes driven by a debounced step button.
module board_clk_ctrl
    import board_clk_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int DIV_DEFAULT = 100000,
    parameter int DB_CYCLES   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             div_ld,
    input  logic [CNT_W-1:0] div_val,
    input  logic             step_btn,
    output logic             cpu_ce,
    output logic             slow_clk,
    output logic [31:0]      cycle_cnt,
    output logic             running
);

    localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = (DIV_DEFAULT < 1) ? DIV_ONE : CNT_W'(DIV_DEFAULT);

    state_t           r_state;
    state_t           w_mode_st;
    state_t           w_next;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_run_ce;
    logic             w_ce_next;
    logic             w_clr;
    logic             r_cpu_ce;
    logic             r_slow;
    logic             r_running;
    logic [31:0]      r_cycle_cnt;
    logic             w_btn_level;
    logic             w_btn_rise;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (step_btn),
        .level (w_btn_level),
        .rise  (w_btn_rise)
    );

    // Next state: follow mode, except an armed step with a fresh button edge fires once.
    always_comb begin
        w_mode_st = mode_to_state(mode);
        w_next    = w_mode_st;
        case (r_state)
            ST_STEP_ARMED: begin
                if ((w_mode_st == ST_STEP_ARMED) && w_btn_rise) begin
                    w_next = ST_STEP_FIRE;
                end else begin
                    w_next = w_mode_st;
                end
            end
            default: w_next = w_mode_st;
        endcase
    end

    // Divider and pulse decode; a RUN pulse is dropped when leaving RUN so HALT stays quiet.
    always_comb begin
        w_clr     = div_ld || (w_next != r_state);
        w_run_ce  = (r_state == ST_RUN) && (w_next == ST_RUN) && (r_cnt >= (r_div - DIV_ONE));
        w_ce_next = w_run_ce || (w_next == ST_STEP_FIRE);
        if (w_clr || (w_next != ST_RUN) || w_run_ce) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + DIV_ONE;
        end
    end

    // State register and divide-ratio register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HALT;
            r_div   <= DIV_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (div_ld) begin
                r_div <= (div_val == '0) ? DIV_ONE : div_val;
            end else begin
                r_div <= r_div;
            end
        end
    end

    // Registered outputs; cycle_cnt counts a pulse as it is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_ce    <= 1'b0;
            r_slow      <= 1'b0;
            r_running   <= 1'b0;
            r_cycle_cnt <= 32'd0;
        end else begin
            r_cpu_ce  <= w_ce_next;
            r_slow    <= r_slow ^ r_cpu_ce;
            r_running <= (w_next == ST_RUN);
            if (w_ce_next) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
        end
    end

    assign cpu_ce    = r_cpu_ce;
    assign slow_clk  = r_slow;
    assign cycle_cnt = r_cycle_cnt;
    assign running   = r_running;

endmodule
